// File: rtl/ast_conv_pkg.sv
// Shared definitions for the Avalon-ST width converters: geometry helpers,
// beat index type and the converter FSM state encoding.
package ast_conv_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } conv_state_e;

    function automatic int bytes_out(input int data_out_w);
        return data_out_w / 8;
    endfunction

    function automatic int ratio(input int data_in_w, input int data_out_w);
        return data_in_w / data_out_w;
    endfunction

    function automatic int idx_width(input int r);
        return (r <= 2) ? 1 : $clog2(r);
    endfunction

    localparam int DEF_RATIO = ratio(64, 16);

    // Beat index for the default 64 -> 16 geometry.
    typedef logic [idx_width(DEF_RATIO)-1:0] beat_idx_t;

endpackage

// File: rtl/ast_width_downsizer.sv
// Avalon-ST down-converter: splits each wide input beat into RATIO (or fewer,
// on a short EOP word) narrow output beats, most significant chunk first.
module ast_width_downsizer
    import ast_conv_pkg::*;
#(
    parameter int DATA_IN_W   = 64,
    parameter int DATA_OUT_W  = 16,
    parameter int EMPTY_IN_W  = 3,
    parameter int EMPTY_OUT_W = 1,
    parameter int CHANNEL_W   = 10
) (
    input  logic                   clk,
    input  logic                   srst,
    input  logic [DATA_IN_W-1:0]   ast_data_i,
    input  logic                   ast_startofpacket_i,
    input  logic                   ast_endofpacket_i,
    input  logic                   ast_valid_i,
    input  logic [EMPTY_IN_W-1:0]  ast_empty_i,
    input  logic [CHANNEL_W-1:0]   ast_channel_i,
    output logic                   ast_ready_o,
    output logic [DATA_OUT_W-1:0]  ast_data_o,
    output logic                   ast_startofpacket_o,
    output logic                   ast_endofpacket_o,
    output logic                   ast_valid_o,
    output logic [EMPTY_OUT_W-1:0] ast_empty_o,
    output logic [CHANNEL_W-1:0]   ast_channel_o,
    input  logic                   ast_ready_i
);

    localparam int BYTES_OUT = bytes_out(DATA_OUT_W);
    localparam int RATIO     = ratio(DATA_IN_W, DATA_OUT_W);
    localparam int IDX_W     = idx_width(RATIO);

    typedef logic [IDX_W-1:0] idx_t;

    conv_state_e            state_q, state_d;
    logic [DATA_IN_W-1:0]   word_q;
    logic                   sop_q, eop_q;
    logic [EMPTY_OUT_W-1:0] empty_q, empty_d;
    logic [CHANNEL_W-1:0]   chan_q;
    idx_t                   idx_q, last_q, last_d;
    logic [DATA_IN_W-1:0]   word_shifted;
    logic                   in_acc, out_acc, at_last, load, advance;

    // Handshake: a beat moves on a side only in a cycle where that side's valid
    // and ready are both high. ready_o opens when the holding register is empty
    // or its final narrow beat is leaving, so words stream without bubbles.
    assign ast_valid_o = (state_q == ST_SEND);
    assign at_last     = (idx_q == last_q);
    assign ast_ready_o = !srst && (!ast_valid_o || (ast_ready_i && at_last));
    assign in_acc      = ast_valid_i && ast_ready_o;
    assign out_acc     = ast_valid_o && ast_ready_i;

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        advance = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (in_acc) begin
                    load    = 1'b1;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (out_acc) begin
                    if (!at_last) begin
                        advance = 1'b1;
                    end else if (in_acc) begin
                        load = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Empty is only meaningful on EOP words; whole unused chunks shorten the word.
    always_comb begin
        last_d  = idx_t'(RATIO - 1);
        empty_d = '0;
        if (ast_endofpacket_i) begin
            last_d  = idx_t'(RATIO - 1 - int'(ast_empty_i) / BYTES_OUT);
            empty_d = EMPTY_OUT_W'(int'(ast_empty_i) % BYTES_OUT);
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            state_q <= ST_IDLE;
            word_q  <= '0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
            empty_q <= '0;
            chan_q  <= '0;
            idx_q   <= '0;
            last_q  <= '0;
        end else begin
            state_q <= state_d;
            if (load) begin
                word_q  <= ast_data_i;
                sop_q   <= ast_startofpacket_i;
                eop_q   <= ast_endofpacket_i;
                empty_q <= empty_d;
                chan_q  <= ast_channel_i;
                idx_q   <= '0;
                last_q  <= last_d;
            end else if (advance) begin
                idx_q <= idx_q + 1'b1;
            end
        end
    end

    assign word_shifted        = word_q << (int'(idx_q) * DATA_OUT_W);
    assign ast_data_o          = word_shifted[DATA_IN_W-1 -: DATA_OUT_W];
    assign ast_startofpacket_o = ast_valid_o && sop_q && (idx_q == '0);
    assign ast_endofpacket_o   = ast_valid_o && eop_q && at_last;
    assign ast_empty_o         = ast_endofpacket_o ? empty_q : '0;
    assign ast_channel_o       = chan_q;

endmodule
